sw_debounce: RTL and testbench

- Conditions the raw slide-switch bus `SW` before it reaches the LED/logic stage. That stage consumes `SW_DB` in place of `SW`.
- Per bit, the block does two things:
  - synchronises the asynchronous switch level into the `CLOCK_50` domain;
  - filters contact bounce, accepting a new level only after it has been stable for `DEBOUNCE_CYCLES` consecutive clocks.
- It also produces one-cycle rise/fall event pulses per bit for downstream edge-triggered logic.

---
 rtl/sw_debounce.sv | 73 +++++++
 tb/tb_sw_debounce.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/sw_debounce.sv
// sw_debounce
//   Conditions the raw slide-switch bus before it reaches the LED/logic stage.
//   Each bit is handled independently:
//   - A two-flop synchroniser brings the asynchronous level into the CLOCK_50 domain.
//   - A per-bit counter accepts a new level only after it has been seen for
//     DEBOUNCE_CYCLES consecutive clocks.
//   - The block emits one-cycle rise and fall pulses on the edge where the
//     debounced level changes.
//
// Parameters
//   WIDTH            number of switch bits
//   DEBOUNCE_CYCLES  consecutive stable cycles needed to accept a new level (>= 1)
//   CNT_WIDTH        per-bit counter width, 2**CNT_WIDTH >= DEBOUNCE_CYCLES
//
// Ports
//   CLOCK_50  system clock; all state changes on its rising edge
//   reset     synchronous, active-high; clears every register
//   SW        raw asynchronous switch levels
//   SW_DB     debounced, registered switch levels
//   SW_RISE   one-cycle pulse when SW_DB[i] goes 0->1
//   SW_FALL   one-cycle pulse when SW_DB[i] goes 1->0
module sw_debounce #(
  parameter int WIDTH           = 10,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_WIDTH       = 19
) (
  input  logic             CLOCK_50,
  input  logic             reset,
  input  logic [WIDTH-1:0] SW,
  output logic [WIDTH-1:0] SW_DB,
  output logic [WIDTH-1:0] SW_RISE,
  output logic [WIDTH-1:0] SW_FALL
);

  // The count at which the candidate level has been stable long enough.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0]     s1;
  logic [WIDTH-1:0]     s2;
  logic [CNT_WIDTH-1:0] cnt [WIDTH];

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      s1      <= '0;
      s2      <= '0;
      SW_DB   <= '0;
      SW_RISE <= '0;
      SW_FALL <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      s1      <= SW;
      s2      <= s1;
      SW_RISE <= '0;
      SW_FALL <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) begin
        if (s2[i] == SW_DB[i]) begin
          // Any cycle agreeing with the accepted level restarts the count.
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          SW_DB[i]   <= s2[i];
          cnt[i]     <= '0;
          SW_RISE[i] <= s2[i];
          SW_FALL[i] <= ~s2[i];
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sw_debounce.sv
// Testbench for sw_debounce.
// Directed vector tables, hand-written multi-cycle sequences and randomized
// stimulus. Every edge is compared against a reference model built from the
// recorded input and reset history.
module tb_sw_debounce;

  localparam int W  = 10;
  localparam int DC = 4;
  localparam int CW = 3;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] sw;
  logic [W-1:0] sw_db;
  logic [W-1:0] sw_rise;
  logic [W-1:0] sw_fall;

  always #5 clk = ~clk;

  sw_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC),
    .CNT_WIDTH      (CW)
  ) dut (
    .CLOCK_50(clk),
    .reset   (reset),
    .SW      (sw),
    .SW_DB   (sw_db),
    .SW_RISE (sw_rise),
    .SW_FALL (sw_fall)
  );

  int n_cmp = 0;
  int n_mis = 0;

  // Per-edge history: the switch word, the reset level, and the level the
  // filter sees at that edge (the switch word two edges earlier, or 0 if
  // reset touched either synchroniser stage in between).
  logic [W-1:0] sw_h  [$];
  bit           rst_h [$];
  logic [W-1:0] x_h   [$];

  logic [W-1:0] m_db   = '0;
  logic [W-1:0] m_rise = '0;
  logic [W-1:0] m_fall = '0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s @edge %0d: got %h expected %h", name, sw_h.size() - 1, act, exp);
    end
  endtask

  function automatic logic [W-1:0] filt_in(input int n);
    if (n < 2) return '0;
    if (rst_h[n-1] || rst_h[n-2]) return '0;
    return sw_h[n-2];
  endfunction

  // Drive one edge, then update the model and compare all outputs.
  // A bit flips when the last DC filter inputs were all non-reset edges that
  // disagreed with the current debounced level.
  task automatic tick(input logic [W-1:0] v, input bit r);
    int           n;
    logic [W-1:0] nd;
    logic [W-1:0] t;
    bit           stable;
    sw    = v;
    reset = r;
    @(posedge clk);
    #1;
    sw_h.push_back(v);
    rst_h.push_back(r);
    n = sw_h.size() - 1;
    x_h.push_back(filt_in(n));
    m_rise = '0;
    m_fall = '0;
    if (r) begin
      m_db = '0;
    end else begin
      nd = m_db;
      for (int i = 0; i < W; i++) begin
        stable = (n + 1 >= DC);
        for (int j = 0; j < DC && stable; j++) begin
          t = x_h[n-j];
          if (rst_h[n-j] || t[i] == m_db[i]) stable = 1'b0;
        end
        if (stable) nd[i] = ~m_db[i];
      end
      m_rise = nd & ~m_db;
      m_fall = ~nd & m_db;
      m_db   = nd;
    end
    check("model_db",   sw_db,   m_db);
    check("model_rise", sw_rise, m_rise);
    check("model_fall", sw_fall, m_fall);
  endtask

  typedef struct {
    bit           rst;
    logic [W-1:0] sw;
    logic [W-1:0] db;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
  } vec_t;

  vec_t tbl [$];

  task automatic add(input bit r, input logic [W-1:0] s, input logic [W-1:0] d,
                     input logic [W-1:0] ri, input logic [W-1:0] fa, input int reps);
    vec_t e;
    e.rst = r; e.sw = s; e.db = d; e.rise = ri; e.fall = fa;
    for (int k = 0; k < reps; k++) tbl.push_back(e);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] v;
    logic [W-1:0] cur;
    bit           pat [8];
    sw    = '0;
    reset = 1'b1;

    // Reset, clean rise, full rise, clean fall, multi-bit swap.
    add(1, 10'h000, 10'h000, 10'h000, 10'h000, 2);
    add(0, 10'h000, 10'h000, 10'h000, 10'h000, 2);
    add(0, 10'h001, 10'h000, 10'h000, 10'h000, 5);
    add(0, 10'h001, 10'h001, 10'h001, 10'h000, 1);
    add(0, 10'h001, 10'h001, 10'h000, 10'h000, 1);
    add(0, 10'h3FF, 10'h001, 10'h000, 10'h000, 5);
    add(0, 10'h3FF, 10'h3FF, 10'h3FE, 10'h000, 1);
    add(0, 10'h3FF, 10'h3FF, 10'h000, 10'h000, 1);
    add(0, 10'h3FE, 10'h3FF, 10'h000, 10'h000, 5);
    add(0, 10'h3FE, 10'h3FE, 10'h000, 10'h001, 1);
    add(0, 10'h3FE, 10'h3FE, 10'h000, 10'h000, 1);
    add(0, 10'h00F, 10'h3FE, 10'h000, 10'h000, 5);
    add(0, 10'h00F, 10'h00F, 10'h001, 10'h3F0, 1);
    add(0, 10'h00F, 10'h00F, 10'h000, 10'h000, 1);
    add(0, 10'h0F0, 10'h00F, 10'h000, 10'h000, 5);
    add(0, 10'h0F0, 10'h0F0, 10'h0F0, 10'h00F, 1);
    add(0, 10'h0F0, 10'h0F0, 10'h000, 10'h000, 1);

    foreach (tbl[k]) begin
      tick(tbl[k].sw, tbl[k].rst);
      check($sformatf("vec%0d_db", k),   sw_db,   tbl[k].db);
      check($sformatf("vec%0d_rise", k), sw_rise, tbl[k].rise);
      check($sformatf("vec%0d_fall", k), sw_fall, tbl[k].fall);
    end

    // Bounce on bit 3: runs of three are too short, then a stable run is accepted.
    pat = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int e = 0; e < 8; e++) begin
      v    = 10'h0F0;
      v[3] = pat[e];
      tick(v, 1'b0);
      check("bounce_db3",    sw_db & 10'h008,               10'h000);
      check("bounce_pulse3", (sw_rise | sw_fall) & 10'h008, 10'h000);
    end
    for (int e = 0; e < 7; e++) begin
      tick(10'h0F8, 1'b0);
      if (e < 5) begin
        check("settle_db",   sw_db,   10'h0F0);
        check("settle_rise", sw_rise, 10'h000);
      end else if (e == 5) begin
        check("accept_db",   sw_db,   10'h0F8);
        check("accept_rise", sw_rise, 10'h008);
        check("accept_fall", sw_fall, 10'h000);
      end else begin
        check("after_rise",  sw_rise, 10'h000);
      end
    end

    // Single-cycle glitch on bit 9.
    tick(10'h2F8, 1'b0);
    check("glitch_db", sw_db, 10'h0F8);
    for (int e = 0; e < 8; e++) begin
      tick(10'h0F8, 1'b0);
      check("glitch_db",    sw_db,             10'h0F8);
      check("glitch_pulse", sw_rise | sw_fall, 10'h000);
    end

    // Reset during a count abandons it; the count restarts after release.
    for (int e = 0; e < 12; e++) begin
      tick(10'h200, (e == 3 || e == 4));
      if (e < 3) begin
        check("rstmid_db", sw_db, 10'h0F8);
      end else if (e < 10) begin
        check("rstmid_db", sw_db, 10'h000);
      end else begin
        check("rstmid_db", sw_db, 10'h200);
      end
      check("rstmid_rise", sw_rise, (e == 10) ? 10'h200 : 10'h000);
      check("rstmid_fall", sw_fall, 10'h000);
    end

    // Randomized: long holds, single-edge glitches, occasional reset.
    cur = 10'h200;
    for (int e = 0; e < 3000; e++) begin
      if ($urandom_range(0, 19) == 0) cur = W'($urandom);
      v = cur;
      if ($urandom_range(0, 3) == 0) v = cur ^ W'($urandom);
      tick(v, ($urandom_range(0, 299) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
